// File: rtl/block_judge_scheduler.sv
// Per-frame sweep controller for the block-judging datapath.
// Walks every block slot once per frame, times each read through the block
// memory and state processor, applies the resulting verdict and keeps the
// score/combo/health/game-over status. Judged blocks get a retire write.

module block_judge_scheduler #(
   parameter int NUM_BLOCKS   = 64,
   parameter int READ_LATENCY = 2,
   parameter int SLICE_POINTS = 10,
   parameter int MISS_DAMAGE  = 10,
   parameter int HIT_DAMAGE   = 25,
   parameter int START_HEALTH = 100
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        frame_start_in,
   input  logic        restart_in,
   input  logic [1:0]  state_in,
   output logic        block_rd_out,
   output logic [7:0]  block_addr_out,
   input  logic        block_visible_in,
   input  logic        sliced_in,
   input  logic        hit_in,
   input  logic        missed_in,
   output logic        retire_we_out,
   output logic [7:0]  retire_index_out,
   output logic [15:0] score_out,
   output logic [7:0]  combo_out,
   output logic [7:0]  health_out,
   output logic        game_over_out,
   output logic        busy_out,
   output logic        sweep_done_out,
   output logic [7:0]  overrun_out
);

   localparam logic [1:0]  PLAYING   = 2'b01;
   localparam logic [7:0]  LAST_IDX  = 8'(NUM_BLOCKS - 1);
   localparam int          WAIT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(READ_LATENCY - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [7:0]  HIT_DMG   = 8'(HIT_DAMAGE);
   localparam logic [7:0]  MISS_DMG  = 8'(MISS_DAMAGE);
   localparam logic [7:0]  START_HP  = 8'(START_HEALTH);
   localparam logic [16:0] SLICE_ADD = 17'(SLICE_POINTS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_COLLECT,
      S_DONE
   } sweep_state_t;

   sweep_state_t      state_q, state_d;
   logic [7:0]        idx_q, idx_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              visible_q, visible_d;
   logic              pending_q, pending_d;
   logic [7:0]        overrun_q, overrun_d;
   logic [15:0]       score_q, score_d;
   logic [7:0]        combo_q, combo_d;
   logic [7:0]        health_q, health_d;

   logic              playing;
   logic              restart_ok;
   logic              apply_verdict;
   logic              do_hit, do_slice, do_miss;
   logic              fatal_damage;
   logic [16:0]       score_sum;
   logic              sweep_active;

   assign playing      = (state_in == PLAYING);
   assign restart_ok   = (state_q == S_IDLE) && restart_in;
   assign sweep_active = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_COLLECT);

   // Pick the single verdict applied this cycle: hit beats sliced beats missed,
   // and nothing counts for an invisible block or once the game has left PLAYING.
   always_comb begin
      apply_verdict = (state_q == S_COLLECT) && playing && visible_q;
      do_hit        = apply_verdict && hit_in;
      do_slice      = apply_verdict && !hit_in && sliced_in;
      do_miss       = apply_verdict && !hit_in && !sliced_in && missed_in;
   end

   // Next score/combo/health, including restart reload and saturating arithmetic.
   always_comb begin
      score_sum = {1'b0, score_q} + SLICE_ADD;
      score_d   = score_q;
      combo_d   = combo_q;
      health_d  = health_q;
      if (restart_ok) begin
         score_d  = 16'd0;
         combo_d  = 8'd0;
         health_d = START_HP;
      end else if (do_hit) begin
         health_d = (health_q > HIT_DMG) ? (health_q - HIT_DMG) : 8'd0;
         combo_d  = 8'd0;
      end else if (do_slice) begin
         score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
         combo_d  = (combo_q == 8'hFF) ? 8'hFF : (combo_q + 8'd1);
      end else if (do_miss) begin
         health_d = (health_q > MISS_DMG) ? (health_q - MISS_DMG) : 8'd0;
         combo_d  = 8'd0;
      end
      fatal_damage = (do_hit || do_miss) && (health_d == 8'd0);
   end

   // Sweep sequencing, frame-start queueing and abort handling.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wait_d    = wait_q;
      visible_d = visible_q;
      pending_d = pending_q;
      overrun_d = overrun_q;

      case (state_q)
         S_IDLE: begin
            idx_d     = 8'd0;
            wait_d    = '0;
            pending_d = 1'b0;
            if (restart_in) begin
               overrun_d = 8'd0;
            end else if (frame_start_in && playing && !game_over_out) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q == LAST_WAIT) begin
               visible_d = block_visible_in;
               state_d   = S_COLLECT;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
         S_COLLECT: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = 8'd0;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            idx_d     = 8'd0;
            pending_d = pending_q && frame_start_in;
            if (pending_q || frame_start_in) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (sweep_active && frame_start_in) begin
         if (!pending_q) begin
            pending_d = 1'b1;
         end else if (overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
         end
      end

      if ((state_q != S_IDLE) && (!playing || fatal_damage)) begin
         state_d   = S_IDLE;
         idx_d     = 8'd0;
         wait_d    = '0;
         pending_d = 1'b0;
      end
   end

   // State and status registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         idx_q     <= 8'd0;
         wait_q    <= '0;
         visible_q <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 8'd0;
         score_q   <= 16'd0;
         combo_q   <= 8'd0;
         health_q  <= START_HP;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wait_q    <= wait_d;
         visible_q <= visible_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         score_q   <= score_d;
         combo_q   <= combo_d;
         health_q  <= health_d;
      end
   end

   assign block_rd_out     = (state_q == S_FETCH);
   assign block_addr_out   = idx_q;
   assign retire_we_out    = do_hit || do_slice || do_miss;
   assign retire_index_out = idx_q;
   assign score_out        = score_q;
   assign combo_out        = combo_q;
   assign health_out       = health_q;
   assign game_over_out    = (health_q == 8'd0);
   assign busy_out         = (state_q != S_IDLE);
   assign sweep_done_out   = (state_q == S_DONE);
   assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_block_judge_scheduler.sv
// Self-checking bench for block_judge_scheduler with a 4-slot sweep.
// A cycle-position model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations on top.

module tb_block_judge_scheduler;

   localparam int NB       = 4;
   localparam int RL       = 2;
   localparam int PER      = RL + 2;
   localparam int DONE_POS = NB * PER;
   localparam int SLICE    = 10;
   localparam int MISS     = 10;
   localparam int HIT      = 25;
   localparam int START    = 100;
   localparam logic [1:0] PLAY = 2'b01;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        frame_start_in = 1'b0;
   logic        restart_in = 1'b0;
   logic [1:0]  state_in = PLAY;
   logic        block_rd_out;
   logic [7:0]  block_addr_out;
   logic        block_visible_in;
   logic        sliced_in, hit_in, missed_in;
   logic        retire_we_out;
   logic [7:0]  retire_index_out;
   logic [15:0] score_out;
   logic [7:0]  combo_out, health_out, overrun_out;
   logic        game_over_out, busy_out, sweep_done_out;

   logic [3:0]  visVec = 4'hF;
   logic [3:0]  sliceVec = 4'h0;
   logic [3:0]  hitVec = 4'h0;
   logic [3:0]  missVec = 4'h0;

   int compared = 0;
   int mismatched = 0;
   int doneCount = 0;
   int retireCount = 0;
   int lastRetire = -1;

   bit mBusy = 1'b0;
   int mPos = 0;
   bit mPending = 1'b0;
   int mScore = 0;
   int mCombo = 0;
   int mHealth = START;
   int mOverrun = 0;

   assign block_visible_in = visVec[block_addr_out[1:0]];
   assign sliced_in        = sliceVec[block_addr_out[1:0]];
   assign hit_in           = hitVec[block_addr_out[1:0]];
   assign missed_in        = missVec[block_addr_out[1:0]];

   block_judge_scheduler #(
      .NUM_BLOCKS(NB),
      .READ_LATENCY(RL),
      .SLICE_POINTS(SLICE),
      .MISS_DAMAGE(MISS),
      .HIT_DAMAGE(HIT),
      .START_HEALTH(START)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .frame_start_in(frame_start_in),
      .restart_in(restart_in),
      .state_in(state_in),
      .block_rd_out(block_rd_out),
      .block_addr_out(block_addr_out),
      .block_visible_in(block_visible_in),
      .sliced_in(sliced_in),
      .hit_in(hit_in),
      .missed_in(missed_in),
      .retire_we_out(retire_we_out),
      .retire_index_out(retire_index_out),
      .score_out(score_out),
      .combo_out(combo_out),
      .health_out(health_out),
      .game_over_out(game_over_out),
      .busy_out(busy_out),
      .sweep_done_out(sweep_done_out),
      .overrun_out(overrun_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic frame, input logic restart, input logic [1:0] st);
      @(posedge clk_in);
      #1;
      frame_start_in = frame;
      restart_in     = restart;
      state_in       = st;
   endtask

   task automatic runSweep(input string name);
      bit finished;
      finished = 1'b0;
      applyStimulus(1'b1, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      for (int k = 0; k < 200; k++) begin
         if (!busy_out) begin
            finished = 1'b1;
            break;
         end
         applyStimulus(1'b0, 1'b0, PLAY);
      end
      if (!finished) checkOutput({name, "_timeout"}, 1, 0);
   endtask

   // Reference model: the sweep is a position counter advancing one cycle at a time.
   always @(posedge clk_in or posedge rst_in) begin
      bit abort;
      bit oldPend;
      int i;
      if (rst_in) begin
         mBusy = 1'b0; mPos = 0; mPending = 1'b0;
         mScore = 0; mCombo = 0; mHealth = START; mOverrun = 0;
      end else if (!mBusy) begin
         if (restart_in) begin
            mScore = 0; mCombo = 0; mHealth = START; mOverrun = 0;
         end else if (frame_start_in && state_in == PLAY && mHealth != 0) begin
            mBusy = 1'b1; mPos = 0;
         end
      end else begin
         abort = 1'b0;
         oldPend = mPending;
         if (mPos == DONE_POS) begin
            mPending = oldPend && frame_start_in;
            if (oldPend || frame_start_in) mPos = 0;
            else mBusy = 1'b0;
         end else begin
            if (mPos % PER == PER - 1 && state_in == PLAY) begin
               i = mPos / PER;
               if (visVec[i]) begin
                  if (hitVec[i]) begin
                     mHealth = (mHealth > HIT) ? mHealth - HIT : 0;
                     mCombo = 0;
                     if (mHealth == 0) abort = 1'b1;
                  end else if (sliceVec[i]) begin
                     mScore = (mScore + SLICE > 65535) ? 65535 : mScore + SLICE;
                     mCombo = (mCombo == 255) ? 255 : mCombo + 1;
                  end else if (missVec[i]) begin
                     mHealth = (mHealth > MISS) ? mHealth - MISS : 0;
                     mCombo = 0;
                     if (mHealth == 0) abort = 1'b1;
                  end
               end
            end
            mPos++;
            if (frame_start_in) begin
               if (!oldPend) mPending = 1'b1;
               else if (mOverrun < 255) mOverrun++;
            end
         end
         if (state_in != PLAY || abort) begin
            mBusy = 1'b0;
            mPending = 1'b0;
         end
      end
   end

   // Per-cycle comparison of every output against the model, plus event tallies.
   always @(negedge clk_in) begin
      bit expRd, expDone, expRet;
      int i;
      if (!rst_in) begin
         i = mPos / PER;
         if (i > NB - 1) i = NB - 1;
         expRd   = mBusy && mPos < DONE_POS && (mPos % PER == 0);
         expDone = mBusy && mPos == DONE_POS;
         expRet  = mBusy && mPos < DONE_POS && (mPos % PER == PER - 1) && state_in == PLAY
                   && visVec[i] && (hitVec[i] || sliceVec[i] || missVec[i]);
         checkOutput("busy", int'(busy_out), int'(mBusy));
         checkOutput("rd", int'(block_rd_out), int'(expRd));
         if (expRd) checkOutput("rd_addr", int'(block_addr_out), i);
         checkOutput("sweep_done", int'(sweep_done_out), int'(expDone));
         checkOutput("retire_we", int'(retire_we_out), int'(expRet));
         if (expRet) checkOutput("retire_idx", int'(retire_index_out), i);
         checkOutput("score", int'(score_out), mScore);
         checkOutput("combo", int'(combo_out), mCombo);
         checkOutput("health", int'(health_out), mHealth);
         checkOutput("game_over", int'(game_over_out), int'(mHealth == 0));
         checkOutput("overrun", int'(overrun_out), mOverrun);
         if (sweep_done_out) doneCount++;
         if (retire_we_out) begin
            retireCount++;
            lastRetire = int'(retire_index_out);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
      mismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rdCount, rdFirst, rdLast, doneAt, doneBase, retBase;
      rst_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;

      // Reset values
      checkOutput("rst_health", int'(health_out), 100);
      checkOutput("rst_score", int'(score_out), 0);
      checkOutput("rst_busy", int'(busy_out), 0);
      checkOutput("rst_overrun", int'(overrun_out), 0);

      // Scenario 1: sweep timing with nothing to judge
      $display("[TB] scenario 1: sweep timing");
      rdCount = 0; rdFirst = -1; rdLast = -1; doneAt = -1;
      applyStimulus(1'b1, 1'b0, PLAY);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_in);
         if (block_rd_out) begin
            rdCount++;
            if (rdFirst < 0) rdFirst = k;
            rdLast = k;
         end
         if (sweep_done_out) doneAt = k;
         applyStimulus(1'b0, 1'b0, PLAY);
      end
      checkOutput("s1_rd_count", rdCount, 4);
      checkOutput("s1_rd_first", rdFirst, 1);
      checkOutput("s1_rd_last", rdLast, 13);
      checkOutput("s1_done_cycle", doneAt, 17);
      checkOutput("s1_score", int'(score_out), 0);

      // Scenario 2: slicing index 2 over three frames builds the combo
      $display("[TB] scenario 2: slices");
      sliceVec = 4'b0100;
      retBase = retireCount;
      runSweep("s2a");
      checkOutput("s2_retire_idx", lastRetire, 2);
      checkOutput("s2_retire_count", retireCount - retBase, 1);
      checkOutput("s2_score1", int'(score_out), 10);
      checkOutput("s2_combo1", int'(combo_out), 1);
      runSweep("s2b");
      runSweep("s2c");
      checkOutput("s2_score3", int'(score_out), 30);
      checkOutput("s2_combo3", int'(combo_out), 3);

      // Scenario 3: misses on invisible vs visible blocks
      $display("[TB] scenario 3: misses");
      sliceVec = 4'b0000;
      missVec  = 4'b0010;
      visVec   = 4'b1101;
      retBase = retireCount;
      runSweep("s3a");
      checkOutput("s3_invis_retires", retireCount - retBase, 0);
      checkOutput("s3_invis_health", int'(health_out), 100);
      checkOutput("s3_invis_combo", int'(combo_out), 3);
      visVec = 4'hF;
      runSweep("s3b");
      checkOutput("s3_health", int'(health_out), 90);
      checkOutput("s3_combo", int'(combo_out), 0);

      // Scenario 4: hit priority, then damage to zero
      $display("[TB] scenario 4: hits");
      missVec = 4'b0000;
      applyStimulus(1'b0, 1'b1, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      checkOutput("s4_restart_health", int'(health_out), 100);
      hitVec   = 4'b0001;
      sliceVec = 4'b0001;
      runSweep("s4a");
      checkOutput("s4_health", int'(health_out), 75);
      checkOutput("s4_score", int'(score_out), 0);
      checkOutput("s4_combo", int'(combo_out), 0);
      hitVec   = 4'hF;
      sliceVec = 4'h0;
      doneBase = doneCount;
      retBase  = retireCount;
      runSweep("s4b");
      checkOutput("s4_health_zero", int'(health_out), 0);
      checkOutput("s4_game_over", int'(game_over_out), 1);
      checkOutput("s4_abort_no_done", doneCount - doneBase, 0);
      checkOutput("s4_abort_retires", retireCount - retBase, 3);
      applyStimulus(1'b1, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      checkOutput("s4_frame_ignored", int'(busy_out), 0);
      applyStimulus(1'b1, 1'b1, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      checkOutput("s4_restart_wins_busy", int'(busy_out), 0);
      checkOutput("s4_restart_health2", int'(health_out), 100);
      checkOutput("s4_restart_go", int'(game_over_out), 0);
      hitVec = 4'h0;

      // Scenario 5: extra frame pulses during a sweep
      $display("[TB] scenario 5: frame overrun");
      doneBase = doneCount;
      applyStimulus(1'b1, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      applyStimulus(1'b1, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      applyStimulus(1'b1, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      for (int k = 0; k < 200 && busy_out; k++) applyStimulus(1'b0, 1'b0, PLAY);
      checkOutput("s5_idle", int'(busy_out), 0);
      checkOutput("s5_sweeps", doneCount - doneBase, 2);
      checkOutput("s5_overrun", int'(overrun_out), 1);

      // Scenario 6: leaving PLAYING mid-WAIT, then restart
      $display("[TB] scenario 6: abort and restart");
      sliceVec = 4'b0001;
      runSweep("s6a");
      checkOutput("s6_score_pre", int'(score_out), 10);
      doneBase = doneCount;
      retBase  = retireCount;
      applyStimulus(1'b1, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, 2'b00);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("s6_abort_busy", int'(busy_out), 0);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("s6_abort_score", int'(score_out), 10);
      checkOutput("s6_abort_no_done", doneCount - doneBase, 0);
      checkOutput("s6_abort_no_retire", retireCount - retBase, 0);
      applyStimulus(1'b0, 1'b1, 2'b00);
      applyStimulus(1'b0, 1'b0, PLAY);
      checkOutput("s6_restart_score", int'(score_out), 0);
      checkOutput("s6_restart_combo", int'(combo_out), 0);
      checkOutput("s6_restart_health", int'(health_out), 100);
      checkOutput("s6_restart_overrun", int'(overrun_out), 0);

      // Reset asserted in the middle of a sweep
      $display("[TB] scenario 7: reset mid-sweep");
      runSweep("s7a");
      checkOutput("s7_score_pre", int'(score_out), 10);
      applyStimulus(1'b1, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      applyStimulus(1'b0, 1'b0, PLAY);
      rst_in = 1'b1;
      #1;
      checkOutput("s7_rst_busy", int'(busy_out), 0);
      checkOutput("s7_rst_rd", int'(block_rd_out), 0);
      checkOutput("s7_rst_score", int'(score_out), 0);
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b0;
      applyStimulus(1'b0, 1'b0, PLAY);
      checkOutput("s7_post_busy", int'(busy_out), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
